// File: rtl/hi_lo_mult_div.sv
// Iterative multiply/divide unit owning the HI/LO architectural registers.
// One radix-2 step per cycle in RUN, sign fix-up and HI/LO write in FIX.
module hi_lo_mult_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             sig_mt_hi,
  input  logic             sig_mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_next;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 q_neg, r_neg;
  logic [2*WIDTH-1:0]   acc, acc_step, prod_fix;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       shifted, diff;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 div_zero, use_sign;

  // Divide-by-zero is run as an unsigned divide with no sign fix, which
  // naturally yields an all-ones quotient and the raw dividend as remainder.
  assign div_zero = op[1] && (rt_data == '0);
  assign use_sign = !op[0] && !div_zero;
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divide keeps the partial remainder in acc's upper half and shifts
  // quotient bits into the lower half; multiply accumulates MSB-first.
  always_comb begin
    shifted = {acc[2*WIDTH-1:WIDTH], a_mag[WIDTH-1]};
    diff    = shifted - {1'b0, b_mag};
    if (op_q[1]) begin
      if (diff[WIDTH]) acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_step = {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {acc[2*WIDTH-2:0], 1'b0} +
                 (b_mag[WIDTH-1] ? {{WIDTH{1'b0}}, a_mag} : '0);
    end
    prod_fix = q_neg ? -acc : acc;
    quo_fix  = q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (sig_mt_hi) hi_reg <= mt_data;
          if (sig_mt_lo) lo_reg <= mt_data;
          if (start) begin
            op_q  <= op;
            a_mag <= (use_sign && rs_data[WIDTH-1]) ? -rs_data : rs_data;
            b_mag <= (use_sign && rt_data[WIDTH-1]) ? -rt_data : rt_data;
            q_neg <= use_sign && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            r_neg <= use_sign && rs_data[WIDTH-1];
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
          if (op_q[1]) a_mag <= {a_mag[WIDTH-2:0], 1'b0};
          else         b_mag <= {b_mag[WIDTH-2:0], 1'b0};
        end
        FIX: begin
          if (op_q[1]) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_mult_div.sv
// Directed self-checking bench for hi_lo_mult_div: arithmetic, latency,
// divide corner cases, busy-time interference, MT writes and async reset.
module tb_hi_lo_mult_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, mt_data;
  logic        sig_mt_hi, sig_mt_lo;
  logic        busy, done;
  logic [31:0] hi_reg, lo_reg;

  int errors = 0;
  int checks = 0;

  hi_lo_mult_div dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .sig_mt_hi(sig_mt_hi), .sig_mt_lo(sig_mt_lo), .mt_data(mt_data),
    .busy(busy), .done(done), .hi_reg(hi_reg), .lo_reg(lo_reg)
  );

  always #5 clk = ~clk;

  // Issues one operation from a negedge and samples every following negedge
  // for 40 cycles; optional interference is applied after sample 'inj'.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, b,
                        input int inj, output logic [31:0] h, l,
                        output int busy_cyc, output int done_cnt,
                        output logic held);
    logic [31:0] h0, l0;
    h0 = hi_reg; l0 = lo_reg; h = h0; l = l0;
    busy_cyc = 0; done_cnt = 0; held = 1'b1;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0; sig_mt_hi = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++; h = hi_reg; l = lo_reg;
      end else if (busy && (hi_reg !== h0 || lo_reg !== l0)) held = 1'b0;
      if (i == inj) begin
        start = 1'b1; op = 2'b00; sig_mt_hi = 1'b1; mt_data = 32'hDEADBEEF;
        rs_data = ~a; rt_data = 32'h3;
      end
    end
  endtask

  task automatic expect_hl(input string name, input logic [31:0] h, l,
                           input logic [31:0] eh, el);
    checks++;
    if (h !== eh || l !== el) begin
      errors++;
      $display("FAIL %s: hi=%h lo=%h, required hi=%h lo=%h", name, h, l, eh, el);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mt_data = '0; sig_mt_hi = 1'b0; sig_mt_lo = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_reg !== 32'h0 || lo_reg !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero",
               busy, done, hi_reg, lo_reg);
    end
  endtask

  task automatic test_multu_latency();
    logic [31:0] h, l; int bc, dc; logic held;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, h, l, bc, dc, held);
    expect_hl("multu_max", h, l, 32'hFFFFFFFE, 32'h00000001);
    checks++;
    if (bc !== 33) begin
      errors++; $display("FAIL multu_busy_cycles: got %0d, required 33", bc);
    end
    checks++;
    if (dc !== 1) begin
      errors++; $display("FAIL multu_done_pulses: got %0d, required 1", dc);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++; $display("FAIL multu_hold_during_run: got %b, required 1", held);
    end
  endtask

  task automatic test_signed_ops();
    logic [31:0] h, l; int bc, dc; logic held;
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, -1, h, l, bc, dc, held);
    expect_hl("mult_neg3_x7", h, l, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1, h, l, bc, dc, held);
    expect_hl("div_neg7_by2", h, l, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, -1, h, l, bc, dc, held);
    expect_hl("div_7_by_neg2", h, l, 32'h00000001, 32'hFFFFFFFD);
    run_op(2'b11, 32'd100, 32'd7, -1, h, l, bc, dc, held);
    expect_hl("divu_100_by7", h, l, 32'd2, 32'd14);
    run_op(2'b01, 32'h80000000, 32'd4, -1, h, l, bc, dc, held);
    expect_hl("multu_carry_hi", h, l, 32'h00000002, 32'h00000000);
  endtask

  task automatic test_div_corners();
    logic [31:0] h, l; int bc, dc; logic held;
    run_op(2'b11, 32'h12345678, 32'h0, -1, h, l, bc, dc, held);
    expect_hl("divu_by_zero", h, l, 32'h12345678, 32'hFFFFFFFF);
    checks++;
    if (bc !== 33) begin
      errors++; $display("FAIL divzero_busy_cycles: got %0d, required 33", bc);
    end
    run_op(2'b10, 32'h80000005, 32'h0, -1, h, l, bc, dc, held);
    expect_hl("div_signed_by_zero", h, l, 32'h80000005, 32'hFFFFFFFF);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, h, l, bc, dc, held);
    expect_hl("div_overflow", h, l, 32'h00000000, 32'h80000000);
  endtask

  task automatic test_busy_interference();
    logic [31:0] h, l; int bc, dc; logic held;
    run_op(2'b11, 32'd100, 32'd7, 10, h, l, bc, dc, held);
    expect_hl("divu_ignores_start_mt", h, l, 32'd2, 32'd14);
    checks++;
    if (dc !== 1) begin
      errors++; $display("FAIL interference_done_pulses: got %0d, required 1", dc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL no_queued_start: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_mt_and_async_reset();
    logic [31:0] h, l; int bc, dc; logic held;
    sig_mt_hi = 1'b1; mt_data = 32'hAAAA5555;
    @(negedge clk);
    sig_mt_hi = 1'b0; sig_mt_lo = 1'b1; mt_data = 32'h00001234;
    @(negedge clk);
    sig_mt_lo = 1'b0;
    expect_hl("mthi_mtlo", hi_reg, lo_reg, 32'hAAAA5555, 32'h00001234);
    sig_mt_hi = 1'b1; sig_mt_lo = 1'b1; mt_data = 32'h0BADF00D;
    @(negedge clk);
    sig_mt_hi = 1'b0; sig_mt_lo = 1'b0;
    expect_hl("mt_both_same_edge", hi_reg, lo_reg, 32'h0BADF00D, 32'h0BADF00D);
    op = 2'b01; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_reg !== 32'h0 || lo_reg !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_midop: busy=%b done=%b hi=%h lo=%h, required all zero",
               busy, done, hi_reg, lo_reg);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(2'b01, 32'd3, 32'd5, -1, h, l, bc, dc, held);
    expect_hl("multu_after_reset", h, l, 32'h0, 32'd15);
    checks++;
    if (dc !== 1) begin
      errors++; $display("FAIL after_reset_done_pulses: got %0d, required 1", dc);
    end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_signed_ops();
    test_div_corners();
    test_busy_interference();
    test_mt_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
